// File: rtl/fixed_point_adder_arbiter_if.sv
// Bundle between the requesting clients, the arbiter and the shared fixed-point adder.
// slave = arbiter view, master = view of whatever drives requests and models the adder.
interface fixed_point_adder_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    // client side
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] op_a;
    logic [N*WIDTH-1:0] op_b;
    logic [N-1:0]       gnt;
    logic [N-1:0]       rsp_valid;
    logic [WIDTH-1:0]   rsp_val;
    logic               rsp_overflow;
    logic               rsp_err;
    logic               busy;

    // adder side
    logic               add_start;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_busy;
    logic               add_done;
    logic               add_valid;
    logic               add_overflow;
    logic [WIDTH-1:0]   add_val;

    modport slave (
        input  req, op_a, op_b,
        input  add_busy, add_done, add_valid, add_overflow, add_val,
        output gnt, rsp_valid, rsp_val, rsp_overflow, rsp_err, busy,
        output add_start, add_a, add_b
    );

    modport master (
        output req, op_a, op_b,
        output add_busy, add_done, add_valid, add_overflow, add_val,
        input  gnt, rsp_valid, rsp_val, rsp_overflow, rsp_err, busy,
        input  add_start, add_a, add_b
    );
endinterface

// File: rtl/fixed_point_adder_arbiter.sv
// Round-robin arbiter that time-shares one fixed-point adder among N clients:
// accept one operand pair, pulse start, wait for done (or watchdog), route the result back.
module fixed_point_adder_arbiter #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int FBITS   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    fixed_point_adder_arbiter_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit PARAMS_OK = (N >= 2) && (TIMEOUT >= 2) && (FBITS >= 0) && (FBITS <= WIDTH);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("fixed_point_adder_arbiter: illegal N, TIMEOUT or FBITS");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [PW-1:0]    ptr_reg;
    logic [PW-1:0]    idx_reg;
    logic [CW-1:0]    cnt_reg;
    logic [N-1:0]     gnt_reg;
    logic [N-1:0]     rsp_valid_reg;
    logic [WIDTH-1:0] rsp_val_reg;
    logic             rsp_overflow_reg;
    logic             rsp_err_reg;
    logic             busy_reg;
    logic             add_start_reg;
    logic [WIDTH-1:0] add_a_reg;
    logic [WIDTH-1:0] add_b_reg;

    logic [WIDTH-1:0] op_a_arr [N];
    logic [WIDTH-1:0] op_b_arr [N];
    logic [N-1:0]     win_onehot;
    logic [N-1:0]     idx_onehot;
    logic [PW-1:0]    win_idx;
    logic [PW:0]      cand;
    logic [CW-1:0]    cnt_inc;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slices
            assign op_a_arr[gi]   = bus.op_a[gi*WIDTH +: WIDTH];
            assign op_b_arr[gi]   = bus.op_b[gi*WIDTH +: WIDTH];
            assign win_onehot[gi] = (win_idx == PW'(gi));
            assign idx_onehot[gi] = (idx_reg == PW'(gi));
        end
    endgenerate

    // Walk offsets from farthest to nearest so the requester closest to ptr ends up winning.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_reg} + (PW+1)'(k);
            if (cand >= (PW+1)'(N)) begin
                cand = cand - (PW+1)'(N);
            end
            if (bus.req[cand[PW-1:0]]) begin
                win_idx = cand[PW-1:0];
            end
        end
    end

    // Watchdog fires when the post-increment count hits TIMEOUT-1, so RESP lands TIMEOUT cycles after ISSUE.
    assign cnt_inc = cnt_reg + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg        <= IDLE;
            ptr_reg          <= '0;
            idx_reg          <= '0;
            cnt_reg          <= '0;
            gnt_reg          <= '0;
            rsp_valid_reg    <= '0;
            rsp_val_reg      <= '0;
            rsp_overflow_reg <= 1'b0;
            rsp_err_reg      <= 1'b0;
            busy_reg         <= 1'b0;
            add_start_reg    <= 1'b0;
            add_a_reg        <= '0;
            add_b_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|bus.req && !bus.add_busy) begin
                        idx_reg       <= win_idx;
                        add_a_reg     <= op_a_arr[win_idx];
                        add_b_reg     <= op_b_arr[win_idx];
                        gnt_reg       <= win_onehot;
                        add_start_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt_reg       <= '0;
                    add_start_reg <= 1'b0;
                    ptr_reg       <= (idx_reg == PW'(N - 1)) ? '0 : idx_reg + 1'b1;
                    cnt_reg       <= '0;
                    state_reg     <= WAIT;
                end
                WAIT: begin
                    cnt_reg <= cnt_inc;
                    if (bus.add_done) begin
                        rsp_val_reg      <= bus.add_val;
                        rsp_overflow_reg <= bus.add_overflow;
                        rsp_err_reg      <= !bus.add_valid;
                        rsp_valid_reg    <= idx_onehot;
                        state_reg        <= RESP;
                    end else if (cnt_inc == CW'(TIMEOUT - 1)) begin
                        rsp_val_reg      <= '0;
                        rsp_overflow_reg <= 1'b0;
                        rsp_err_reg      <= 1'b1;
                        rsp_valid_reg    <= idx_onehot;
                        state_reg        <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_reg <= '0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt          = gnt_reg;
    assign bus.rsp_valid    = rsp_valid_reg;
    assign bus.rsp_val      = rsp_val_reg;
    assign bus.rsp_overflow = rsp_overflow_reg;
    assign bus.rsp_err      = rsp_err_reg;
    assign bus.busy         = busy_reg;
    assign bus.add_start    = add_start_reg;
    assign bus.add_a        = add_a_reg;
    assign bus.add_b        = add_b_reg;
endmodule

// File: tb/tb_fixed_point_adder_arbiter.sv
// Bench for fixed_point_adder_arbiter: behavioural adder plus a transaction-level scoreboard
// (round-robin pointer, expected grant/response cycle and payload), directed cases then random traffic.
module tb_fixed_point_adder_arbiter;
    localparam int N       = 4;
    localparam int WIDTH   = 8;
    localparam int FBITS   = 4;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fixed_point_adder_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

    fixed_point_adder_arbiter #(
        .N(N), .WIDTH(WIDTH), .FBITS(FBITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // stimulus state
    logic [N-1:0]     req_drv;
    logic [WIDTH-1:0] opa_drv [N];
    logic [WIDTH-1:0] opb_drv [N];
    bit rst_drv, busy_force, hold_req, rand_mode, rand_adder, stale_req;
    int next_lat;
    bit next_valid;

    // behavioural adder
    bit               add_pend;
    int               done_at;
    logic [WIDTH-1:0] add_res;
    bit               add_ovf_res, add_valid_res;

    // values the DUT saw at the last edge
    logic [N-1:0]     app_req;
    bit               app_busy, app_rst;
    logic [WIDTH-1:0] app_opa [N];
    logic [WIDTH-1:0] app_opb [N];

    // reference model
    int ptr_m, wake_m, exp_idx, exp_rsp_obs;
    bit free_m, active_m;
    logic [WIDTH-1:0] exp_val, exp_a, exp_b;
    bit exp_ovf, exp_err;
    int rsp_count;

    // DUT observations used by directed checks
    int dut_gnt_log [$];
    int dut_gnt_count, dut_rsp_count, last_gnt_cyc, last_rsp_cyc;
    logic [N-1:0]     last_rsp_vec;
    logic [WIDTH-1:0] last_val;
    logic             last_ovf, last_err;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic bit signed_ovf(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    task automatic apply_inputs();
        rst      = rst_drv;
        app_rst  = rst_drv;
        bus.req  = req_drv;
        app_req  = req_drv;
        for (int k = 0; k < N; k++) begin
            bus.op_a[k*WIDTH +: WIDTH] = opa_drv[k];
            bus.op_b[k*WIDTH +: WIDTH] = opb_drv[k];
            app_opa[k] = opa_drv[k];
            app_opb[k] = opb_drv[k];
        end
        bus.add_busy = busy_force | add_pend;
        app_busy     = busy_force | add_pend;
    endtask

    task automatic step();
        logic [N-1:0]     exp_g, exp_rv;
        logic [WIDTH-1:0] s;
        int w, lat;
        bit vld;
        @(posedge clk);
        #1;
        cyc++;
        exp_g = '0;
        exp_rv = '0;
        w = -1;
        // raw DUT observations
        if (bus.gnt != 0) begin
            dut_gnt_count++;
            last_gnt_cyc = cyc;
            for (int k = 0; k < N; k++) if (bus.gnt[k]) dut_gnt_log.push_back(k);
        end
        if (bus.rsp_valid != 0) begin
            dut_rsp_count++;
            last_rsp_cyc = cyc;
            last_rsp_vec = bus.rsp_valid;
            last_val     = bus.rsp_val;
            last_ovf     = bus.rsp_overflow;
            last_err     = bus.rsp_err;
        end

        if (app_rst) begin
            check_eq("rst_gnt", bus.gnt, 0);
            check_eq("rst_rsp_valid", bus.rsp_valid, 0);
            check_eq("rst_rsp_val", bus.rsp_val, 0);
            check_eq("rst_rsp_ovf", bus.rsp_overflow, 0);
            check_eq("rst_rsp_err", bus.rsp_err, 0);
            check_eq("rst_busy", bus.busy, 0);
            check_eq("rst_add_start", bus.add_start, 0);
            check_eq("rst_add_a", bus.add_a, 0);
            check_eq("rst_add_b", bus.add_b, 0);
            ptr_m = 0; free_m = 1; wake_m = 0; active_m = 0; add_pend = 0;
        end else begin
            if (wake_m > 0) begin
                wake_m--;
                if (wake_m == 0) free_m = 1;
            end
            if (free_m && (app_req != 0) && !app_busy) begin
                w = rr_pick(app_req, ptr_m);
                if (w >= 0) exp_g[w] = 1'b1;
            end
            check_eq("gnt", bus.gnt, exp_g);
            check_eq("add_start", bus.add_start, exp_g != 0);
            if (exp_g != 0) begin
                free_m = 0; active_m = 1;
                ptr_m = (w + 1) % N;
                exp_idx = w; exp_a = app_opa[w]; exp_b = app_opb[w];
                lat = rand_adder ? $urandom_range(1, TIMEOUT + 3) : next_lat;
                vld = rand_adder ? ($urandom_range(0, 9) != 0) : next_valid;
                s = exp_a + exp_b;
                if (lat < TIMEOUT) begin
                    add_pend = 1; done_at = cyc + lat;
                    add_res = s; add_ovf_res = signed_ovf(exp_a, exp_b, s); add_valid_res = vld;
                    exp_rsp_obs = cyc + lat + 1;
                    exp_val = s; exp_ovf = signed_ovf(exp_a, exp_b, s); exp_err = !vld;
                end else begin
                    add_pend = 0;
                    exp_rsp_obs = cyc + TIMEOUT;
                    exp_val = '0; exp_ovf = 0; exp_err = 1;
                end
            end
            if (active_m && cyc == exp_rsp_obs) exp_rv[exp_idx] = 1'b1;
            check_eq("rsp_valid", bus.rsp_valid, exp_rv);
            check_eq("busy", bus.busy, active_m);
            if (active_m) begin
                check_eq("add_a", bus.add_a, exp_a);
                check_eq("add_b", bus.add_b, exp_b);
            end
            if (exp_rv != 0) begin
                check_eq("rsp_val", bus.rsp_val, exp_val);
                check_eq("rsp_ovf", bus.rsp_overflow, exp_ovf);
                check_eq("rsp_err", bus.rsp_err, exp_err);
                $display("txn: req %0d a=0x%02h b=0x%02h -> val=0x%02h ovf=%0b err=%0b at cycle %0d",
                         exp_idx, exp_a, exp_b, bus.rsp_val, bus.rsp_overflow, bus.rsp_err, cyc);
                active_m = 0; wake_m = 2; rsp_count++;
            end
        end

        // next inputs
        if (w >= 0 && !hold_req) req_drv[w] = 1'b0;
        if (rand_mode) begin
            for (int k = 0; k < N; k++) begin
                if (!req_drv[k]) begin
                    if ($urandom_range(0, 99) < 25) begin
                        req_drv[k] = 1'b1;
                        opa_drv[k] = WIDTH'($urandom);
                        opb_drv[k] = WIDTH'($urandom);
                    end
                end else if ($urandom_range(0, 99) < 2) begin
                    req_drv[k] = 1'b0;
                end
            end
        end
        if (rst_drv) add_pend = 0;
        bus.add_done = 0; bus.add_valid = 0; bus.add_overflow = 0; bus.add_val = '0;
        if (add_pend && cyc == done_at) begin
            bus.add_done = 1; bus.add_val = add_res;
            bus.add_overflow = add_ovf_res; bus.add_valid = add_valid_res;
            add_pend = 0;
        end else if (!active_m && (stale_req || (rand_mode && $urandom_range(0, 19) == 0))) begin
            bus.add_done = 1; bus.add_val = WIDTH'($urandom);
            bus.add_overflow = 1'($urandom_range(0, 1)); bus.add_valid = 1'($urandom_range(0, 1));
            stale_req = 0;
        end
        apply_inputs();
    endtask

    task automatic wait_rsp(int budget);
        int target;
        int n;
        target = rsp_count + 1;
        n = 0;
        while (rsp_count < target && n < budget) begin
            step();
            n++;
        end
        check_eq("wait_rsp_budget", rsp_count >= target, 1);
    endtask

    task automatic wait_grants(int count, int budget);
        int n;
        n = 0;
        while (dut_gnt_log.size() < count && n < budget) begin
            step();
            n++;
        end
        check_eq("wait_gnt_budget", dut_gnt_log.size() >= count, 1);
    endtask

    task automatic do_reset();
        rst_drv = 1; req_drv = '0;
        step();
        step();
        rst_drv = 0;
        step();
    endtask

    initial begin
        int g0, n, r0;
        rst_drv = 1; busy_force = 0; hold_req = 0; rand_mode = 0; rand_adder = 0; stale_req = 0;
        next_lat = 3; next_valid = 1; req_drv = '0; add_pend = 0;
        for (int k = 0; k < N; k++) begin opa_drv[k] = '0; opb_drv[k] = '0; end
        bus.add_done = 0; bus.add_valid = 0; bus.add_overflow = 0; bus.add_val = '0;
        apply_inputs();
        do_reset();

        // single op from requester 1
        opa_drv[1] = 8'h18; opb_drv[1] = 8'h24; req_drv = 4'b0010; next_lat = 3;
        wait_rsp(40);
        check_eq("t1_rsp_vec", last_rsp_vec, 4'b0010);
        check_eq("t1_val", last_val, 8'h3C);
        check_eq("t1_ovf", last_ovf, 0);
        check_eq("t1_err", last_err, 0);

        // overflow from requester 0
        opa_drv[0] = 8'h70; opb_drv[0] = 8'h70; req_drv = 4'b0001; next_lat = 2;
        wait_rsp(40);
        check_eq("t2_val", last_val, 8'hE0);
        check_eq("t2_ovf", last_ovf, 1);
        check_eq("t2_err", last_err, 0);

        // fairness with all requests held, then 0101 with ptr at 1
        do_reset();
        dut_gnt_log.delete();
        for (int k = 0; k < N; k++) begin opa_drv[k] = 8'(k + 1); opb_drv[k] = 8'(16 * k); end
        hold_req = 1; req_drv = 4'b1111; next_lat = 2;
        wait_grants(5, 100);
        hold_req = 0; req_drv = 4'b0101;
        wait_grants(7, 100);
        wait_rsp(40);
        if (dut_gnt_log.size() >= 7) begin
            check_eq("rr_g0", dut_gnt_log[0], 0);
            check_eq("rr_g1", dut_gnt_log[1], 1);
            check_eq("rr_g2", dut_gnt_log[2], 2);
            check_eq("rr_g3", dut_gnt_log[3], 3);
            check_eq("rr_g4", dut_gnt_log[4], 0);
            check_eq("rr_g5", dut_gnt_log[5], 2);
            check_eq("rr_g6", dut_gnt_log[6], 0);
        end

        // adder busy gating
        repeat (3) step();
        busy_force = 1; req_drv = 4'b0001; opa_drv[0] = 8'h11; opb_drv[0] = 8'h22;
        g0 = dut_gnt_count;
        repeat (6) step();
        check_eq("busy_gate_nogrant", dut_gnt_count, g0);
        busy_force = 0;
        n = 0;
        while (dut_gnt_count == g0 && n < 10) begin step(); n++; end
        check_eq("busy_release_latency", n, 2);
        wait_rsp(40);

        // watchdog, then normal service
        opa_drv[2] = 8'h05; opb_drv[2] = 8'h06; req_drv = 4'b0100; next_lat = NEVER;
        wait_rsp(60);
        check_eq("wd_delay", last_rsp_cyc - last_gnt_cyc, TIMEOUT);
        check_eq("wd_err", last_err, 1);
        check_eq("wd_val", last_val, 0);
        opa_drv[2] = 8'h10; opb_drv[2] = 8'h08; req_drv = 4'b0100; next_lat = 4;
        wait_rsp(40);
        check_eq("wd_next_val", last_val, 8'h18);
        check_eq("wd_next_err", last_err, 0);

        // reset during WAIT, then a stale done
        opa_drv[3] = 8'h01; opb_drv[3] = 8'h02; req_drv = 4'b1000; next_lat = NEVER;
        g0 = dut_gnt_count;
        n = 0;
        while (dut_gnt_count == g0 && n < 10) begin step(); n++; end
        repeat (3) step();
        r0 = dut_rsp_count;
        rst_drv = 1;
        step();
        rst_drv = 0;
        step();
        stale_req = 1;
        repeat (20) step();
        check_eq("rst_abort_no_rsp", dut_rsp_count, r0);

        // random traffic
        rand_mode = 1; rand_adder = 1;
        repeat (3000) step();
        rand_mode = 0; req_drv = '0;
        n = 0;
        while (active_m && n < 100) begin step(); n++; end
        check_eq("drain_idle", active_m, 0);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
